// File: rtl/packet_route_port_if.sv
// Stream bus for packet_route_port: one input stream in, CHANNEL_NUMBER-way routed stream out.
// slave is the router side; master is the source/sink side.
interface packet_route_port_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned CHANNEL_NUMBER = 5
) ();

  logic                      in_tvalid;
  logic                      in_tready;
  logic [DATA_WIDTH-1:0]     in_tdata;
  logic [ID_WIDTH-1:0]       in_tid;
  logic                      in_tlast;

  logic [CHANNEL_NUMBER-1:0] out_tvalid;
  logic [CHANNEL_NUMBER-1:0] out_tready;
  logic [DATA_WIDTH-1:0]     out_tdata;
  logic [ID_WIDTH-1:0]       out_tid;
  logic                      out_tlast;

  modport slave (
    input  in_tvalid, in_tdata, in_tid, in_tlast,
    output in_tready,
    output out_tvalid, out_tdata, out_tid, out_tlast,
    input  out_tready
  );

  modport master (
    output in_tvalid, in_tdata, in_tid, in_tlast,
    input  in_tready,
    input  out_tvalid, out_tdata, out_tid, out_tlast,
    output out_tready
  );

endinterface

// File: rtl/packet_route_port.sv
// XY dimension-order mesh router input port: header-locked packet steering into a 2-entry FIFO.
// Optional ROUTE_PORT_PMU_EN adds per-channel header counters and an output stall counter.
module packet_route_port #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned CHANNEL_NUMBER = 5,
  parameter int unsigned MAX_ROUTERS_X  = 4,
  parameter int unsigned MAX_ROUTERS_Y  = 4,
  parameter int unsigned ROUTER_X       = 0,
  parameter int unsigned ROUTER_Y       = 0,
  parameter int unsigned ROUTING_HEADER = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  packet_route_port_if.slave           bus,
  output logic                         err_drop
`ifdef ROUTE_PORT_PMU_EN
  ,
  output logic [CHANNEL_NUMBER*16-1:0] pmu_pkt_cnt,
  output logic [15:0]                  pmu_stall_cnt
`endif
);

  localparam int unsigned XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int unsigned YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
  localparam int unsigned CW = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;

  localparam logic [CW-1:0] CH_LOCAL = CW'(0);
  localparam logic [CW-1:0] CH_NORTH = CW'(1);
  localparam logic [CW-1:0] CH_EAST  = CW'(2);
  localparam logic [CW-1:0] CH_SOUTH = CW'(3);
  localparam logic [CW-1:0] CH_WEST  = CW'(4);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
    logic [CW-1:0]         dest;
  } entry_t;

  state_t                    state_q;
  logic [CW-1:0]             dest_q;
  logic                      err_q;

  logic [XW-1:0]             tx_c;
  logic [YW-1:0]             ty_c;
  logic [CW-1:0]             route_c;
  logic [CW-1:0]             push_dest_c;
  logic                      hdr_c;
  logic                      bad_c;
  logic                      ready_c;
  logic                      acc_c;
  logic                      fwd_c;
  logic                      push_c;
  logic                      pop_c;
  entry_t                    new_c;

  entry_t                    slot0_q, slot0_d;
  entry_t                    slot1_q, slot1_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [CHANNEL_NUMBER-1:0] vld_q, vld_d;

  if (DATA_WIDTH > XW + YW) begin : g_unused
    logic unused_c;
    assign unused_c = ^bus.in_tdata[DATA_WIDTH-1:XW+YW];
  end

  // Header decode and XY route selection
  assign tx_c  = bus.in_tdata[XW-1:0];
  assign ty_c  = bus.in_tdata[XW+YW-1:XW];
  assign hdr_c = (bus.in_tid == ID_WIDTH'(ROUTING_HEADER));
  assign bad_c = (32'(tx_c) >= MAX_ROUTERS_X) || (32'(ty_c) >= MAX_ROUTERS_Y);

  always_comb begin
    route_c = CH_LOCAL;
    if (32'(tx_c) > ROUTER_X)      route_c = CH_EAST;
    else if (32'(tx_c) < ROUTER_X) route_c = CH_WEST;
    else if (32'(ty_c) > ROUTER_Y) route_c = CH_SOUTH;
    else if (32'(ty_c) < ROUTER_Y) route_c = CH_NORTH;
  end

  // Beats that are discarded never wait on FIFO space
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      IDLE:    ready_c = (!hdr_c || bad_c) ? 1'b1 : (cnt_q < 2'd2);
      PASS:    ready_c = (cnt_q < 2'd2);
      DROP:    ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
    if (rst) ready_c = 1'b0;
  end

  assign acc_c       = bus.in_tvalid && ready_c;
  assign fwd_c       = ((state_q == IDLE) && hdr_c && !bad_c) || (state_q == PASS);
  assign push_c      = acc_c && fwd_c;
  assign push_dest_c = (state_q == PASS) ? dest_q : route_c;
  assign pop_c       = |(vld_q & bus.out_tready);

  assign new_c = '{data: bus.in_tdata, id: bus.in_tid, last: bus.in_tlast, dest: push_dest_c};

  // Shift FIFO: slot0 is always the head so outputs come straight from registers
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({push_c, pop_c})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = new_c;
        else               slot1_d = new_c;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = new_c;
        end else begin
          slot0_d = slot1_q;
          slot1_d = new_c;
        end
      end
      default: ;
    endcase
    vld_d = (cnt_d != 2'd0) ? (CHANNEL_NUMBER'(1) << slot0_d.dest) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
      vld_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  // Packet lock FSM with registered drop pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc_c) begin
            if (!hdr_c) begin
              err_q <= 1'b1;
            end else if (bad_c) begin
              err_q   <= 1'b1;
              state_q <= bus.in_tlast ? IDLE : DROP;
            end else begin
              dest_q  <= route_c;
              state_q <= bus.in_tlast ? IDLE : PASS;
            end
          end
        end
        PASS: if (acc_c && bus.in_tlast) state_q <= IDLE;
        DROP: if (acc_c && bus.in_tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_tready  = ready_c;
  assign bus.out_tvalid = vld_q;
  assign bus.out_tdata  = slot0_q.data;
  assign bus.out_tid    = slot0_q.id;
  assign bus.out_tlast  = slot0_q.last;
  assign err_drop       = err_q;

`ifdef ROUTE_PORT_PMU_EN
  logic [CHANNEL_NUMBER-1:0][15:0] pkt_cnt_q;
  logic [15:0]                     stall_cnt_q;
  logic                            hdr_push_c;
  logic                            stall_c;

  assign hdr_push_c = push_c && (state_q == IDLE);
  assign stall_c    = |(vld_q & ~bus.out_tready);

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= 16'd0;
    end else begin
      for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
        if (hdr_push_c && (route_c == CW'(i)) && (pkt_cnt_q[i] != 16'hFFFF))
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
      end
      if (stall_c && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign pmu_pkt_cnt   = pkt_cnt_q;
  assign pmu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_packet_route_port.sv
// Directed self-checking bench for packet_route_port: a 4x4 mesh port and a 3-column port, both at router (1,1).
module tb_packet_route_port;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned CN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_drop;
  logic err_drop3;

  int total = 0;
  int bad   = 0;

  packet_route_port_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN)) bus ();
  packet_route_port_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN)) bus3 ();

`ifdef ROUTE_PORT_PMU_EN
  logic [CN*16-1:0] pkt_cnt, pkt_cnt3;
  logic [15:0]      stall_cnt, stall_cnt3;
`endif

  packet_route_port #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1), .ROUTING_HEADER(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_drop(err_drop)
`ifdef ROUTE_PORT_PMU_EN
    , .pmu_pkt_cnt(pkt_cnt), .pmu_stall_cnt(stall_cnt)
`endif
  );

  packet_route_port #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .CHANNEL_NUMBER(CN),
    .MAX_ROUTERS_X(3), .MAX_ROUTERS_Y(4), .ROUTER_X(1), .ROUTER_Y(1), .ROUTING_HEADER(0)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .err_drop(err_drop3)
`ifdef ROUTE_PORT_PMU_EN
    , .pmu_pkt_cnt(pkt_cnt3), .pmu_stall_cnt(stall_cnt3)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
    bus.in_tvalid = 1'b1;
    bus.in_tdata  = d;
    bus.in_tid    = id;
    bus.in_tlast  = last;
  endtask

  task automatic drv3(input logic [DW-1:0] d, input logic [IW-1:0] id, input logic last);
    bus3.in_tvalid = 1'b1;
    bus3.in_tdata  = d;
    bus3.in_tid    = id;
    bus3.in_tlast  = last;
  endtask

  task automatic test_reset();
    step();
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL rst_vld got=%b exp=%b", bus.out_tvalid, 5'b0); end
    total++; if (bus.out_tdata !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=%h", bus.out_tdata, 32'h0); end
    total++; if ({bus.out_tid, bus.out_tlast} !== 5'b0) begin bad++; $display("FAIL rst_tid_tlast got=%b exp=%b", {bus.out_tid, bus.out_tlast}, 5'b0); end
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_drop); end
    total++; if (bus.in_tready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.in_tready); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_tready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", bus.in_tready); end
  endtask

  // Header to (3,1) from (1,1) goes east; full-rate 4-beat packet
  task automatic test_route_east();
    logic [DW-1:0] exp_d [4];
    exp_d = '{32'h7, 32'hA1, 32'hA2, 32'hA3};
    drv(32'h7, 4'd0, 1'b0);
    total++; if (bus.in_tready !== 1'b1) begin bad++; $display("FAIL east_ready got=%b exp=1", bus.in_tready); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.out_tvalid !== 5'b00100) begin bad++; $display("FAIL east_vld%0d got=%b exp=%b", i, bus.out_tvalid, 5'b00100); end
      total++; if (bus.out_tdata !== exp_d[i]) begin bad++; $display("FAIL east_data%0d got=%h exp=%h", i, bus.out_tdata, exp_d[i]); end
      total++; if (bus.out_tlast !== (i == 3)) begin bad++; $display("FAIL east_last%0d got=%b exp=%b", i, bus.out_tlast, (i == 3)); end
      if (i < 3) drv(exp_d[i+1], 4'd1, (i == 2));
      else       bus.in_tvalid = 1'b0;
    end
    step();
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL east_drain got=%b exp=%b", bus.out_tvalid, 5'b0); end
  endtask

  // Stray body beat in IDLE: swallowed with one drop pulse
  task automatic test_stray_beat();
    drv(32'h55, 4'd1, 1'b0);
    #1;
    total++; if (bus.in_tready !== 1'b1) begin bad++; $display("FAIL stray_ready got=%b exp=1", bus.in_tready); end
    step();
    bus.in_tvalid = 1'b0;
    total++; if (err_drop !== 1'b1) begin bad++; $display("FAIL stray_err got=%b exp=1", err_drop); end
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL stray_vld got=%b exp=%b", bus.out_tvalid, 5'b0); end
    step();
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL stray_err_end got=%b exp=0", err_drop); end
  endtask

  // Single-beat headers to north, south, west, local back to back
  task automatic test_directions();
    logic [DW-1:0] hdr [4];
    logic [CN-1:0] ch  [4];
    hdr = '{32'd1, 32'd13, 32'd8, 32'd5};
    ch  = '{5'b00010, 5'b01000, 5'b10000, 5'b00001};
    drv(hdr[0], 4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (bus.out_tvalid !== ch[i]) begin bad++; $display("FAIL dir_vld%0d got=%b exp=%b", i, bus.out_tvalid, ch[i]); end
      total++; if (bus.out_tdata !== hdr[i] || bus.out_tlast !== 1'b1) begin bad++; $display("FAIL dir_beat%0d got=%h/%b exp=%h/1", i, bus.out_tdata, bus.out_tlast, hdr[i]); end
      if (i < 3) drv(hdr[i+1], 4'd0, 1'b1);
      else       bus.in_tvalid = 1'b0;
    end
    step();
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL dir_drain got=%b exp=%b", bus.out_tvalid, 5'b0); end
  endtask

  // Out-of-mesh header on the 3-column port: whole packet dropped, one pulse
  task automatic test_bad_header();
    drv3(32'h3, 4'd0, 1'b0);
    #1;
    total++; if (bus3.in_tready !== 1'b1) begin bad++; $display("FAIL badh_ready0 got=%b exp=1", bus3.in_tready); end
    step();
    total++; if (err_drop3 !== 1'b1) begin bad++; $display("FAIL badh_err got=%b exp=1", err_drop3); end
    drv3(32'hB1, 4'd1, 1'b0);
    #1;
    total++; if (bus3.in_tready !== 1'b1) begin bad++; $display("FAIL badh_ready1 got=%b exp=1", bus3.in_tready); end
    step();
    total++; if (err_drop3 !== 1'b0) begin bad++; $display("FAIL badh_err1 got=%b exp=0", err_drop3); end
    drv3(32'hB2, 4'd1, 1'b1);
    #1;
    total++; if (bus3.in_tready !== 1'b1) begin bad++; $display("FAIL badh_ready2 got=%b exp=1", bus3.in_tready); end
    step();
    bus3.in_tvalid = 1'b0;
    total++; if (err_drop3 !== 1'b0 || bus3.out_tvalid !== 5'b0) begin bad++; $display("FAIL badh_end got=%b/%b exp=0/00000", err_drop3, bus3.out_tvalid); end
    // Back in IDLE, a stray beat now pulses again
    drv3(32'h77, 4'd2, 1'b0);
    step();
    bus3.in_tvalid = 1'b0;
    total++; if (err_drop3 !== 1'b1) begin bad++; $display("FAIL badh_idle got=%b exp=1", err_drop3); end
    step();
`ifdef ROUTE_PORT_PMU_EN
    total++; if (pkt_cnt3 !== '0) begin bad++; $display("FAIL badh_pmu got=%h exp=0", pkt_cnt3); end
`endif
  endtask

  // East channel stalled 5 cycles: FIFO fills, head held stable
  task automatic test_backpressure();
    bus.out_tready = 5'b11011;
    drv(32'h7, 4'd0, 1'b0);
    step();
    total++; if (bus.out_tvalid !== 5'b00100 || bus.out_tdata !== 32'h7) begin bad++; $display("FAIL bp_head got=%b/%h exp=00100/7", bus.out_tvalid, bus.out_tdata); end
    drv(32'hB1, 4'd1, 1'b0);
    #1;
    total++; if (bus.in_tready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", bus.in_tready); end
    step();
    drv(32'hB2, 4'd1, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.in_tready !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%b exp=0", i, bus.in_tready); end
      total++; if (bus.out_tdata !== 32'h7 || bus.out_tvalid !== 5'b00100) begin bad++; $display("FAIL bp_stable%0d got=%h/%b exp=7/00100", i, bus.out_tdata, bus.out_tvalid); end
      if (i < 4) step();
    end
    bus.out_tready = 5'b11111;
`ifdef ROUTE_PORT_PMU_EN
    total++; if (stall_cnt !== 16'd5) begin bad++; $display("FAIL bp_stall got=%0d exp=5", stall_cnt); end
`endif
    step();
    total++; if (bus.out_tdata !== 32'hB1 || bus.out_tlast !== 1'b0) begin bad++; $display("FAIL bp_b1 got=%h/%b exp=b1/0", bus.out_tdata, bus.out_tlast); end
    total++; if (bus.in_tready !== 1'b1) begin bad++; $display("FAIL bp_ready2 got=%b exp=1", bus.in_tready); end
    step();
    bus.in_tvalid = 1'b0;
    total++; if (bus.out_tdata !== 32'hB2 || bus.out_tlast !== 1'b1 || bus.out_tvalid !== 5'b00100) begin bad++; $display("FAIL bp_b2 got=%h/%b/%b exp=b2/1/00100", bus.out_tdata, bus.out_tlast, bus.out_tvalid); end
    step();
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL bp_drain got=%b exp=%b", bus.out_tvalid, 5'b0); end
`ifdef ROUTE_PORT_PMU_EN
    total++; if (pkt_cnt[2*16 +: 16] !== 16'd2) begin bad++; $display("FAIL pmu_east got=%0d exp=2", pkt_cnt[2*16 +: 16]); end
    total++; if (pkt_cnt[0 +: 16] !== 16'd1 || pkt_cnt[4*16 +: 16] !== 16'd1) begin bad++; $display("FAIL pmu_lw got=%0d/%0d exp=1/1", pkt_cnt[0 +: 16], pkt_cnt[4*16 +: 16]); end
`endif
  endtask

  // Reset mid-packet with a full FIFO, then a fresh header
  task automatic test_mid_reset();
    bus.out_tready = 5'b00000;
    drv(32'h7, 4'd0, 1'b0);
    step();
    drv(32'hC1, 4'd1, 1'b0);
    step();
    drv(32'hC2, 4'd1, 1'b0);
    total++; if (bus.out_tvalid !== 5'b00100) begin bad++; $display("FAIL mr_pre got=%b exp=00100", bus.out_tvalid); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_tvalid !== 5'b0 || bus.in_tready !== 1'b0) begin bad++; $display("FAIL mr_rst got=%b/%b exp=00000/0", bus.out_tvalid, bus.in_tready); end
    step();
    total++; if (bus.out_tvalid !== 5'b0 || bus.out_tdata !== 32'h0) begin bad++; $display("FAIL mr_hold got=%b/%h exp=00000/0", bus.out_tvalid, bus.out_tdata); end
    bus.in_tvalid  = 1'b0;
    bus.out_tready = 5'b11111;
    rst = 1'b0;
    step();
    drv(32'h8, 4'd0, 1'b1);
    step();
    bus.in_tvalid = 1'b0;
    total++; if (bus.out_tvalid !== 5'b10000 || bus.out_tdata !== 32'h8) begin bad++; $display("FAIL mr_west got=%b/%h exp=10000/8", bus.out_tvalid, bus.out_tdata); end
    step();
    total++; if (bus.out_tvalid !== 5'b0) begin bad++; $display("FAIL mr_drain got=%b exp=%b", bus.out_tvalid, 5'b0); end
  endtask

  initial begin
    bus.in_tvalid   = 1'b0;
    bus.in_tdata    = '0;
    bus.in_tid      = '0;
    bus.in_tlast    = 1'b0;
    bus.out_tready  = 5'b11111;
    bus3.in_tvalid  = 1'b0;
    bus3.in_tdata   = '0;
    bus3.in_tid     = '0;
    bus3.in_tlast   = 1'b0;
    bus3.out_tready = 5'b11111;
    test_reset();
    test_route_east();
    test_stray_beat();
    test_directions();
    test_bad_header();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
